// File: rtl/ws2812_pkg.sv
// Shared timing constants and decoder state type for the WS2812 serial receiver.
package ws2812_pkg;

    localparam int unsigned CYCLES_PER_BIT       = 15;
    localparam int unsigned T0H                  = 4;
    localparam int unsigned T1H                  = 8;
    localparam int unsigned PIXEL_BITS           = 24;
    localparam int unsigned NUM_PIXELS_DEFAULT   = 64;
    localparam int unsigned LATCH_CYCLES_DEFAULT = 600;

    typedef enum logic [1:0] {
        RESYNC,
        IDLE,
        HIGH,
        LOW
    } state_t;

endpackage

// File: rtl/ws2812_decoder_sync_2ff.sv
// Two-flop synchronizer bringing the asynchronous data line into the clk domain.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ws2812_decoder.sv
// WS2812 pulse-width decoder: measures din high time per bit, assembles 24-bit
// pixels, and detects the long low latch gap that ends a frame.
module ws2812_decoder
    import ws2812_pkg::*;
#(
    parameter int unsigned HIGH_MIN       = 2,
    parameter int unsigned HIGH_THRESHOLD = 6,
    parameter int unsigned HIGH_MAX       = 12,
    parameter int unsigned LATCH_CYCLES   = LATCH_CYCLES_DEFAULT,
    parameter int unsigned NUM_PIXELS     = NUM_PIXELS_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        din,
    output logic        pixel_valid,
    output logic [23:0] pixel_data,
    output logic [5:0]  pixel_index,
    output logic        frame_done,
    output logic [4:0]  frame,
    output logic        error
);

    localparam int unsigned HW = $clog2(HIGH_MAX + 2);
    localparam int unsigned LW = $clog2(LATCH_CYCLES + 1);
    localparam int unsigned PW = $clog2(NUM_PIXELS + 1);
    localparam int unsigned BW = $clog2(PIXEL_BITS);

    localparam logic [HW-1:0] H_MIN = HW'(HIGH_MIN);
    localparam logic [HW-1:0] H_THR = HW'(HIGH_THRESHOLD);
    localparam logic [HW-1:0] H_MAX = HW'(HIGH_MAX);
    localparam logic [LW-1:0] L_END = LW'(LATCH_CYCLES - 1);
    localparam logic [PW-1:0] P_NUM = PW'(NUM_PIXELS);
    localparam logic [BW-1:0] B_END = BW'(PIXEL_BITS - 1);

    logic                  din_s;
    logic                  din_p;
    state_t                state;
    logic [HW-1:0]         hcnt;
    logic [LW-1:0]         lcnt;
    logic [BW-1:0]         bcnt;
    logic [PW-1:0]         pcnt;
    logic [PIXEL_BITS-1:0] shift;
    logic [PIXEL_BITS-1:0] shift_next;
    logic                  rise;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (din),
        .q     (din_s)
    );

    assign rise       = din_s && !din_p;
    assign shift_next = {shift[PIXEL_BITS-2:0], (hcnt > H_THR)};

    always_ff @(posedge clk) begin
        if (reset) begin
            din_p       <= 1'b0;
            state       <= RESYNC;
            hcnt        <= '0;
            lcnt        <= '0;
            bcnt        <= '0;
            pcnt        <= '0;
            shift       <= '0;
            pixel_valid <= 1'b0;
            pixel_data  <= '0;
            pixel_index <= '0;
            frame_done  <= 1'b0;
            frame       <= '0;
            error       <= 1'b0;
        end else begin
            din_p       <= din_s;
            pixel_valid <= 1'b0;
            frame_done  <= 1'b0;
            error       <= 1'b0;
            case (state)
                RESYNC: begin
                    if (din_s) begin
                        lcnt <= '0;
                    end else if (lcnt == L_END) begin
                        lcnt  <= '0;
                        bcnt  <= '0;
                        pcnt  <= '0;
                        state <= IDLE;
                    end else begin
                        lcnt <= lcnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (rise) begin
                        hcnt  <= HW'(1);
                        state <= HIGH;
                    end
                end
                HIGH: begin
                    if (din_s) begin
                        if (hcnt > H_MAX) begin
                            error <= 1'b1;
                            lcnt  <= '0;
                            state <= RESYNC;
                        end else begin
                            hcnt <= hcnt + 1'b1;
                        end
                    end else if (hcnt < H_MIN || hcnt > H_MAX) begin
                        error <= 1'b1;
                        lcnt  <= '0;
                        state <= RESYNC;
                    end else begin
                        shift <= shift_next;
                        lcnt  <= LW'(1);
                        state <= LOW;
                        if (bcnt == B_END) begin
                            bcnt <= '0;
                            // Pixels beyond the frame size are flagged but not presented.
                            if (pcnt < P_NUM) begin
                                pixel_valid <= 1'b1;
                                pixel_data  <= shift_next;
                                pixel_index <= 6'(pcnt);
                                pcnt        <= pcnt + 1'b1;
                            end else begin
                                error <= 1'b1;
                            end
                        end else begin
                            bcnt <= bcnt + 1'b1;
                        end
                    end
                end
                LOW: begin
                    if (rise) begin
                        hcnt  <= HW'(1);
                        state <= HIGH;
                    end else if (!din_s) begin
                        if (lcnt == L_END) begin
                            lcnt       <= lcnt + 1'b1;
                            frame_done <= 1'b1;
                            frame      <= frame + 1'b1;
                            error      <= (bcnt != '0);
                            bcnt       <= '0;
                            pcnt       <= '0;
                            state      <= IDLE;
                        end else begin
                            lcnt <= lcnt + 1'b1;
                        end
                    end
                end
                default: state <= RESYNC;
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812_decoder.sv
// Directed-plus-random bench for ws2812_decoder with a transaction-level reference model.
module tb_ws2812_decoder;
    import ws2812_pkg::*;

    localparam int unsigned HMIN  = 2;
    localparam int unsigned HTHR  = 6;
    localparam int unsigned HMAX  = 12;
    localparam int unsigned LATCH = 600;
    localparam int unsigned NPIX  = 64;
    localparam int unsigned GAP   = 620;

    logic        clk = 1'b0;
    logic        reset;
    logic        din;
    logic        pixel_valid;
    logic [23:0] pixel_data;
    logic [5:0]  pixel_index;
    logic        frame_done;
    logic [4:0]  frame;
    logic        error;

    ws2812_decoder #(
        .HIGH_MIN       (HMIN),
        .HIGH_THRESHOLD (HTHR),
        .HIGH_MAX       (HMAX),
        .LATCH_CYCLES   (LATCH),
        .NUM_PIXELS     (NPIX)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .din         (din),
        .pixel_valid (pixel_valid),
        .pixel_data  (pixel_data),
        .pixel_index (pixel_index),
        .frame_done  (frame_done),
        .frame       (frame),
        .error       (error)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          n_fd = 0;
    int          n_err = 0;
    time         t_valid = 0;
    time         t_fd = 0;
    time         t_err = 0;
    time         t_fall = 0;
    logic [29:0] got_q[$];
    logic [29:0] exp_q[$];

    // Reference model: link synchronised, bits in current frame, pixel index.
    bit          m_synced = 0;
    int          m_bits = 0;
    int          m_idx = 0;
    logic [23:0] m_shift = '0;
    int          exp_fd = 0;
    int          exp_err = 0;
    int          exp_frame = 0;

    always @(negedge clk) begin
        if (pixel_valid) begin
            got_q.push_back({pixel_index, pixel_data});
            t_valid = $time;
        end
        if (frame_done) begin
            n_fd++;
            t_fd = $time;
        end
        if (error) begin
            n_err++;
            t_err = $time;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_pixels(input string tag);
        check({tag, " pixel count"}, 32'(got_q.size()), 32'(exp_q.size()));
        while (got_q.size() > 0 && exp_q.size() > 0)
            check({tag, " pixel"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_events(input string tag);
        check({tag, " frame_done count"}, 32'(n_fd), 32'(exp_fd));
        check({tag, " error count"}, 32'(n_err), 32'(exp_err));
        check({tag, " frame"}, 32'(frame), 32'(exp_frame % 32));
    endtask

    task automatic hold(input logic v, input int unsigned n);
        din = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, input bit fixed);
        int unsigned hi;
        if (fixed) hi = b ? T1H : T0H;
        else       hi = b ? $urandom_range(HMAX, HTHR + 1) : $urandom_range(HTHR, HMIN);
        hold(1'b1, hi);
        t_fall = $time;
        hold(1'b0, CYCLES_PER_BIT - hi);
        if (m_synced) begin
            m_shift = {m_shift[22:0], b};
            m_bits++;
            if (m_bits % 24 == 0) begin
                if (m_idx < int'(NPIX)) exp_q.push_back({6'(m_idx), m_shift});
                else                    exp_err++;
                m_idx++;
            end
        end
    endtask

    task automatic send_pixel(input logic [23:0] data, input bit fixed);
        for (int i = 23; i >= 0; i--) send_bit(data[i], fixed);
    endtask

    task automatic gap(input int unsigned n);
        hold(1'b0, n);
        if (n >= LATCH) begin
            if (m_synced && m_bits > 0) begin
                exp_fd++;
                exp_frame++;
                if (m_bits % 24 != 0) exp_err++;
            end
            m_synced = 1;
            m_bits   = 0;
            m_idx    = 0;
        end
    endtask

    task automatic bad_pulse(input int unsigned n);
        hold(1'b1, n);
        hold(1'b0, 20);
        if (m_synced) begin
            exp_err++;
            m_synced = 0;
            m_bits   = 0;
            m_idx    = 0;
        end
    endtask

    task automatic apply_reset();
        din   = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset pixel_valid", 32'(pixel_valid), 32'd0);
        check("reset pixel_data", 32'(pixel_data), 32'd0);
        check("reset pixel_index", 32'(pixel_index), 32'd0);
        check("reset frame_done", 32'(frame_done), 32'd0);
        check("reset frame", 32'(frame), 32'd0);
        check("reset error", 32'(error), 32'd0);
        m_synced  = 0;
        m_bits    = 0;
        m_idx     = 0;
        exp_frame = 0;
        reset = 1'b0;
    endtask

    initial begin
        logic [23:0] base;
        int unsigned pulses[3];
        pulses[0] = 1;
        pulses[1] = 13;
        pulses[2] = 14;
        din   = 1'b0;
        reset = 1'b1;
        @(negedge clk);

        // Single known pixel with nominal timings, latency and hold behaviour.
        apply_reset();
        gap(LATCH);
        send_pixel(24'hA53CF0, 1);
        check("single latency", 32'(t_valid - t_fall), 32'd30);
        check_pixels("single");
        check_events("single pre-gap");
        gap(GAP);
        check("single hold data", 32'(pixel_data), 32'hA53CF0);
        check("single hold index", 32'(pixel_index), 32'd0);
        check_events("single");

        // Full frame of incrementing data with randomised pulse widths.
        base = 24'($urandom);
        for (int p = 0; p < int'(NPIX); p++) send_pixel(base + 24'(p), 0);
        gap(GAP);
        check_pixels("full frame");
        check_events("full frame");

        // Overflow pixel, then a fresh frame restarting at index 0.
        for (int p = 0; p <= int'(NPIX); p++) send_pixel(24'($urandom), 0);
        gap(GAP);
        check_pixels("overflow");
        check_events("overflow");
        send_pixel(24'($urandom), 0);
        gap(GAP);
        check_pixels("after overflow");
        check_events("after overflow");

        // Malformed pulses force resync; data before a full gap is ignored.
        foreach (pulses[k]) begin
            gap(GAP);
            bad_pulse(pulses[k]);
            check_events("bad pulse");
        end
        send_pixel(24'($urandom), 0);
        check_pixels("during resync");
        gap(GAP);
        send_pixel(24'($urandom), 0);
        gap(GAP);
        check_pixels("after resync");
        check_events("after resync");

        // Partial pixel at the latch point: error and frame_done together.
        for (int i = 0; i < 10; i++) send_bit(1'($urandom), 0);
        gap(GAP);
        check("partial same cycle", 32'(t_err), 32'(t_fd));
        check_pixels("partial");
        check_events("partial");

        // Reset in the middle of pixel 5, bit 12.
        for (int p = 0; p < 5; p++) send_pixel(24'($urandom), 0);
        for (int i = 0; i < 12; i++) send_bit(1'($urandom), 0);
        hold(1'b1, 3);
        apply_reset();
        check_pixels("pre reset");
        send_pixel(24'($urandom), 0);
        gap(GAP);
        check_pixels("post reset unsynced");
        send_pixel(24'($urandom), 0);
        gap(GAP);
        check_pixels("post reset");
        check_events("post reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
